pcie_width_converter: RTL
=========================

# pcie_width_converter

Single-clock, parametrised bidirectional width converter between the PCIe-side wide stream and the NPU-side narrow stream. The unpack path splits each wide beat into narrow words, honouring per-lane keep and packet last. The pack path gathers narrow words into wide beats, including partial final beats, with an optional idle-flush timer. It sits on the `clk` side of the PCIe clock-domain-crossing FIFOs, between them and the NPU core.

## Interface
- `NARROW_WIDTH`, 32, NPU word width in bits.
- `WIDE_WIDTH`, 128, PCIe beat width; `WIDE_WIDTH/NARROW_WIDTH` (RATIO) must be an integer power of two, 2 or more.
- `FLUSH_TIMEOUT`, 64, idle cycles before a partial pack beat is flushed (used only with the macro); 1 to 65535.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wide_rx_data`  in  WIDE_WIDTH  unpack input beat; lane i = bits [i*NARROW_WIDTH +: NARROW_WIDTH].
- `wide_rx_keep`  in  RATIO  per-lane valid.
- `wide_rx_last`  in  1  beat ends packet.
- `wide_rx_valid` in 1, `wide_rx_ready` out 1  input handshake.
- `narrow_out_data` out NARROW_WIDTH, `narrow_out_last` out 1, `narrow_out_valid` out 1, `narrow_out_ready` in 1  unpack output.
- `narrow_in_data` in NARROW_WIDTH, `narrow_in_last` in 1, `narrow_in_valid` in 1, `narrow_in_ready` out 1  pack input.
- `wide_tx_data` out WIDE_WIDTH, `wide_tx_keep` out RATIO, `wide_tx_last` out 1, `wide_tx_valid` out 1, `wide_tx_ready` in 1  pack output.
- `drop_count`  out  8  saturating count of keep==0 beats dropped.
- `status`  out  4  {unpack_busy, pack_partial, wide_tx_valid, narrow_out_valid}.

## Operation
- All transfers complete when valid && ready on the same rising edge. Valid, once asserted, holds with stable data until accepted. Ready is independent of same-cycle data.
- Unpack: a one-beat holding register stores data, keep, last, and a remaining-lane mask.
  - Lanes are emitted in ascending index, skipping keep=0 lanes.
  - `narrow_out_last` = held last AND current lane is the highest kept lane.
  - `wide_rx_ready` = holding empty OR (one lane remaining AND `narrow_out_ready`), which gives back-to-back beats.
  - A keep==0 beat is accepted and discarded, produces no output, and increments `drop_count` (saturates at 255). Its last flag is lost.
- Pack: an accumulator (data, keep, lane pointer) feeds an output register.
  - A non-completing word writes lane[pointer] and advances the pointer.
  - A completing word (pointer==RATIO-1 or `narrow_in_last`=1) moves the accumulator plus that word into the output register, with last = `narrow_in_last`, and resets the pointer to 0.
  - Unfilled lanes are data 0, keep 0.
  - `narrow_in_ready` = !`wide_tx_valid` OR `wide_tx_ready`.
- `unpack_busy` = holding register occupied. `pack_partial` = accumulator pointer ≠ 0.

## Timing
- Reset values: all valids 0, `wide_rx_ready` 1, `narrow_in_ready` 1, all data/keep/last outputs 0, `drop_count` 0, `status` 4'b0000.
- Unpack latency: the first narrow word is valid 1 cycle after wide acceptance. Throughput is one narrow word per cycle.
- Pack latency: a wide beat is valid 1 cycle after its completing word is accepted. Throughput is one narrow word per cycle while `wide_tx_ready`=1.
- If `wide_tx_ready` is held 0 with a beat pending, `narrow_in_ready` drops to 0 and the accumulator is frozen.
- Both paths are fully independent and may transfer in the same cycle.
- Reset mid-operation discards held and accumulated data immediately. There is no partial output after reset.

## Configuration
- `PCIE_WC_FLUSH_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs while `pack_partial`=1. It clears on any accepted narrow word and saturates.
  - On reaching FLUSH_TIMEOUT with the output register free, the accumulator moves to the output register with `wide_tx_last`=0 and keep = filled lanes. The pointer resets to 0.
  - If the output register is busy, the flush waits until it is free.
- Not defined: partial beats wait indefinitely for further words or last. The counter is absent.

## Test plan
- Unpack: beat 0x4444_4444_3333_3333_2222_2222_1111_1111, keep 4'b1111, last=1, sink always ready → words 0x1111_1111, 0x2222_2222, 0x3333_3333, 0x4444_4444 on 4 consecutive cycles; last only on the 4th.
- Unpack: keep 4'b1010, last=1 → lane 1 then lane 3, last on lane 3. A following keep 4'b0000 beat → no output, `drop_count`=1.
- Pack: 6 words 1..6, last on word 6 → beat1 keep 4'b1111, data {4,3,2,1}, last 0. Beat2 keep 4'b0011, data {0,0,6,5}, last 1.
- Backpressure: `wide_tx_ready`=0 for 10 cycles during a continuous 8-word stream → `narrow_in_ready`=0 after the 4th word, no data lost or reordered, and both beats appear after release.
- With `PCIE_WC_FLUSH_TIMEOUT_EN`, FLUSH_TIMEOUT=8: 2 words then idle → beat with keep 4'b0011, last 0, valid 9 cycles after the 2nd word. Without the macro → no beat after 100 cycles.
- Assert `rst_n`=0 mid-packet on both paths → all valids 0 and `status`=0 in the same cycle; the next packet after release converts correctly.

Source files
------------

// File: rtl/pcie_width_converter.sv
// Bidirectional PCIe<->NPU stream width converter: unpacks wide beats into narrow words and packs narrow words into wide beats.
// Define PCIE_WC_FLUSH_TIMEOUT_EN to flush partial pack beats after FLUSH_TIMEOUT idle cycles.
module pcie_width_converter #(
    parameter int unsigned NARROW_WIDTH  = 32,
    parameter int unsigned WIDE_WIDTH    = 128,
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WIDE_WIDTH-1:0]               wide_rx_data,
    input  logic [WIDE_WIDTH/NARROW_WIDTH-1:0]  wide_rx_keep,
    input  logic                                wide_rx_last,
    input  logic                                wide_rx_valid,
    output logic                                wide_rx_ready,
    output logic [NARROW_WIDTH-1:0]             narrow_out_data,
    output logic                                narrow_out_last,
    output logic                                narrow_out_valid,
    input  logic                                narrow_out_ready,
    input  logic [NARROW_WIDTH-1:0]             narrow_in_data,
    input  logic                                narrow_in_last,
    input  logic                                narrow_in_valid,
    output logic                                narrow_in_ready,
    output logic [WIDE_WIDTH-1:0]               wide_tx_data,
    output logic [WIDE_WIDTH/NARROW_WIDTH-1:0]  wide_tx_keep,
    output logic                                wide_tx_last,
    output logic                                wide_tx_valid,
    input  logic                                wide_tx_ready,
    output logic [7:0]                          drop_count,
    output logic [3:0]                          status
);
    localparam int unsigned RATIO = WIDE_WIDTH / NARROW_WIDTH;
    localparam int unsigned LW    = $clog2(RATIO);

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO * NARROW_WIDTH != WIDE_WIDTH ||
        FLUSH_TIMEOUT < 1 || FLUSH_TIMEOUT > 65535) begin : g_param_check
        $error("pcie_width_converter: invalid parameter set");
    end

    // ---------------- unpack path ----------------
    logic [WIDE_WIDTH-1:0] hold_data;
    logic [RATIO-1:0]      hold_rem;
    logic                  hold_last;
    logic [LW-1:0]         cur_lane;
    logic                  one_left;
    logic                  rx_fire;
    logic                  nout_fire;

    // Lowest remaining lane is the one on the output.
    always_comb begin
        cur_lane = '0;
        for (int unsigned i = RATIO; i > 0; i--) begin
            if (hold_rem[i-1]) cur_lane = LW'(i - 1);
        end
    end

    assign one_left         = (hold_rem != '0) && ((hold_rem & (hold_rem - RATIO'(1))) == '0);
    assign wide_rx_ready    = (hold_rem == '0) || (one_left && narrow_out_ready);
    assign narrow_out_valid = (hold_rem != '0);
    assign narrow_out_data  = hold_data[cur_lane*NARROW_WIDTH +: NARROW_WIDTH];
    assign narrow_out_last  = hold_last && one_left;
    assign rx_fire          = wide_rx_valid && wide_rx_ready;
    assign nout_fire        = narrow_out_valid && narrow_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_rem   <= '0;
            hold_last  <= 1'b0;
            drop_count <= '0;
        end else if (rx_fire) begin
            if (wide_rx_keep == '0) begin
                hold_rem <= '0;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else begin
                hold_data <= wide_rx_data;
                hold_rem  <= wide_rx_keep;
                hold_last <= wide_rx_last;
            end
        end else if (nout_fire) begin
            hold_rem <= hold_rem & (hold_rem - RATIO'(1));
        end
    end

    // ---------------- pack path ----------------
    logic [WIDE_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]      acc_keep;
    logic [LW-1:0]         ptr;
    logic [WIDE_WIDTH-1:0] merged_data;
    logic [RATIO-1:0]      merged_keep;
    logic                  nin_fire;
    logic                  tx_fire;
    logic                  completing;
    logic                  flush;

    assign narrow_in_ready = !wide_tx_valid || wide_tx_ready;
    assign nin_fire        = narrow_in_valid && narrow_in_ready;
    assign tx_fire         = wide_tx_valid && wide_tx_ready;
    assign completing      = nin_fire && (narrow_in_last || ptr == LW'(RATIO - 1));

    always_comb begin
        merged_data = acc_data;
        merged_data[ptr*NARROW_WIDTH +: NARROW_WIDTH] = narrow_in_data;
        merged_keep = acc_keep | (RATIO'(1) << ptr);
    end

`ifdef PCIE_WC_FLUSH_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (nin_fire || flush) begin
            idle_cnt <= '0;
        end else if (ptr != '0 && idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // Output register counts as free when it is empty or draining this cycle.
    assign flush = (ptr != '0) && !nin_fire && narrow_in_ready &&
                   (idle_cnt >= 16'(FLUSH_TIMEOUT));
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data      <= '0;
            acc_keep      <= '0;
            ptr           <= '0;
            wide_tx_data  <= '0;
            wide_tx_keep  <= '0;
            wide_tx_last  <= 1'b0;
            wide_tx_valid <= 1'b0;
        end else if (completing || flush) begin
            wide_tx_data  <= completing ? merged_data : acc_data;
            wide_tx_keep  <= completing ? merged_keep : acc_keep;
            wide_tx_last  <= completing && narrow_in_last;
            wide_tx_valid <= 1'b1;
            acc_data      <= '0;
            acc_keep      <= '0;
            ptr           <= '0;
        end else begin
            if (tx_fire) wide_tx_valid <= 1'b0;
            if (nin_fire) begin
                acc_data <= merged_data;
                acc_keep <= merged_keep;
                ptr      <= ptr + LW'(1);
            end
        end
    end

    assign status = {hold_rem != '0, ptr != '0, wide_tx_valid, narrow_out_valid};

endmodule
